yutorina_fetch_unit: RTL and testbench

- Parametrised instruction fetch stage that replaces the single-register fetch.
- Drives the SPM read port with a running fetch PC and captures each word one cycle later into a small prefetch queue of {pc, instruction} pairs.
- Presents queued entries to decode over a valid/ready handshake.
- Supports redirect (branch/exception) with flush of queued and in-flight words, and backpressure from decode without losing or duplicating fetches.

---
 rtl/yutorina_fetch_unit.sv | 110 +++++++++++
 tb/tb_yutorina_fetch_unit.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/yutorina_fetch_unit.sv
// Instruction fetch stage with a small prefetch queue.
// Issues one SPM read per cycle while queue credit allows, captures the word a
// cycle later together with its PC, and hands entries to decode over
// valid/ready. A redirect flushes queued and in-flight words and restarts fetch.
//
// Ports:
//   clock, reset          stage clock, asynchronous active-high reset
//   spm_read_data         SPM word, valid the cycle after its address
//   spm_read_address      low SPM_ADDR_WIDTH bits of fetch_pc (combinational)
//   spm_read_enable       a fetch is issued this cycle (combinational)
//   redirect_enable/pc    flush and restart fetch at redirect_pc
//   if_ready              decode accepts the head entry
//   if_valid/pc/instruction  head entry presented to decode
//   fetch_pc              next word address to be fetched (registered)
module yutorina_fetch_unit #(
  parameter int unsigned WORD_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 30,
  parameter int unsigned SPM_ADDR_WIDTH = 12,
  parameter int unsigned DEPTH          = 2,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0,
  parameter logic [WORD_WIDTH-1:0] NOP_WORD = '0
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [WORD_WIDTH-1:0]     spm_read_data,
  output logic [SPM_ADDR_WIDTH-1:0] spm_read_address,
  output logic                      spm_read_enable,
  input  logic                      redirect_enable,
  input  logic [ADDR_WIDTH-1:0]     redirect_pc,
  input  logic                      if_ready,
  output logic                      if_valid,
  output logic [ADDR_WIDTH-1:0]     if_pc,
  output logic [WORD_WIDTH-1:0]     if_instruction,
  output logic [ADDR_WIDTH-1:0]     fetch_pc
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned SW = CW + 1;

  logic [ADDR_WIDTH-1:0] pc_q    [DEPTH];
  logic [WORD_WIDTH-1:0] instr_q [DEPTH];
  logic [PW-1:0]         head;
  logic [PW-1:0]         tail;
  logic [CW-1:0]         count;
  logic                  inflight;
  logic [ADDR_WIDTH-1:0] tag_pc;

  logic pop;
  logic push;
  logic issue;
  logic has_entry;

  // Circular pointer advance; DEPTH need not be a power of two.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (32'(p) == DEPTH - 1) ? '0 : p + PW'(1);
  endfunction

  assign has_entry = (count != '0);
  assign if_valid  = has_entry & ~redirect_enable;
  assign pop       = if_valid & if_ready;
  assign push      = inflight & ~redirect_enable;

  // Credit rule: queued + in-flight words never exceed DEPTH after a pop.
  assign issue = ~reset & ~redirect_enable &
                 ((SW'(count) + SW'(inflight)) < (SW'(DEPTH) + SW'(pop)));

  assign spm_read_enable  = issue;
  assign spm_read_address = fetch_pc[SPM_ADDR_WIDTH-1:0];

  assign if_pc          = has_entry ? pc_q[head] : RESET_PC;
  assign if_instruction = if_valid ? instr_q[head] : NOP_WORD;

  // Control state: fetch PC, response tag, occupancy and pointers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      tag_pc   <= RESET_PC;
      inflight <= 1'b0;
      count    <= '0;
      head     <= '0;
      tail     <= '0;
    end else if (redirect_enable) begin
      // Pending response and all queued words are dropped.
      fetch_pc <= redirect_pc;
      inflight <= 1'b0;
      count    <= '0;
      head     <= '0;
      tail     <= '0;
    end else begin
      if (issue) begin
        fetch_pc <= fetch_pc + ADDR_WIDTH'(1);
        tag_pc   <= fetch_pc;
      end
      inflight <= issue;
      if (push) tail <= next_ptr(tail);
      if (pop)  head <= next_ptr(head);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Queue storage; contents are qualified by count, so no reset is needed.
  always_ff @(posedge clock) begin
    if (push) begin
      pc_q[tail]    <= tag_pc;
      instr_q[tail] <= spm_read_data;
    end
  end

endmodule

// File: tb/tb_yutorina_fetch_unit.sv
// Directed bench for yutorina_fetch_unit with a one-cycle-latency SPM model
// holding SPM[n] = 0x1000 + n.
module tb_yutorina_fetch_unit;

  logic        clock;
  logic        reset;
  logic [31:0] spm_read_data;
  logic [11:0] spm_read_address;
  logic        spm_read_enable;
  logic        redirect_enable;
  logic [29:0] redirect_pc;
  logic        if_ready;
  logic        if_valid;
  logic [29:0] if_pc;
  logic [31:0] if_instruction;
  logic [29:0] fetch_pc;

  int total = 0;
  int bad   = 0;

  yutorina_fetch_unit dut (
    .clock            (clock),
    .reset            (reset),
    .spm_read_data    (spm_read_data),
    .spm_read_address (spm_read_address),
    .spm_read_enable  (spm_read_enable),
    .redirect_enable  (redirect_enable),
    .redirect_pc      (redirect_pc),
    .if_ready         (if_ready),
    .if_valid         (if_valid),
    .if_pc            (if_pc),
    .if_instruction   (if_instruction),
    .fetch_pc         (fetch_pc)
  );

  always #5 clock = ~clock;

  // SPM: registered read, content derived from the address.
  always @(posedge clock) begin
    if (spm_read_enable) spm_read_data <= 32'h1000 + 32'(spm_read_address);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic head_is(input string tag, input logic [31:0] pc);
    chk({tag, "_v"},  32'(if_valid), 32'd1);
    chk({tag, "_pc"}, 32'(if_pc), pc);
    chk({tag, "_in"}, if_instruction, 32'h1000 + (pc & 32'hFFF));
  endtask

  task automatic not_valid(input string tag);
    chk({tag, "_v"},  32'(if_valid), 32'd0);
    chk({tag, "_in"}, if_instruction, 32'd0);
  endtask

  // Leaves the bench #1 into cycle 0 after reset release.
  task automatic do_reset(input logic rdy);
    reset = 1'b1;
    redirect_enable = 1'b0;
    if_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    if_ready = rdy;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    clock = 1'b0;
    reset = 1'b1;
    redirect_enable = 1'b0;
    redirect_pc = '0;
    if_ready = 1'b0;
    spm_read_data = '0;
    tick();
    tick();

    // Reset state
    not_valid("rst");
    chk("rst_pc",  32'(if_pc), 32'd0);
    chk("rst_en",  32'(spm_read_enable), 32'd0);
    chk("rst_fpc", 32'(fetch_pc), 32'd0);

    // Startup latency and sustained stream
    reset = 1'b0;
    if_ready = 1'b1;
    #1;
    chk("t1_en0", 32'(spm_read_enable), 32'd1);
    chk("t1_ad0", 32'(spm_read_address), 32'd0);
    not_valid("t1_c0");
    tick();
    not_valid("t1_c1");
    chk("t1_en1", 32'(spm_read_enable), 32'd1);
    chk("t1_ad1", 32'(spm_read_address), 32'd1);
    for (int k = 0; k < 6; k++) begin
      tick();
      head_is("t1_head", 32'(k));
      chk("t1_en", 32'(spm_read_enable), 32'd1);
    end

    // Backpressure: queue fills, fetch stalls, then resumes without skip/dup
    do_reset(1'b1);
    tick();
    tick();
    if_ready = 1'b0;
    #1;
    for (int i = 0; i < 6; i++) begin
      if (i != 0) tick();
      head_is("t2_hold", 32'd0);
      chk("t2_en",  32'(spm_read_enable), 32'd0);
      chk("t2_fpc", 32'(fetch_pc), 32'd2);
    end
    tick();
    if_ready = 1'b1;
    #1;
    head_is("t2_res", 32'd0);
    chk("t2_ren", 32'(spm_read_enable), 32'd1);
    chk("t2_rad", 32'(spm_read_address), 32'd2);
    for (int k = 1; k < 6; k++) begin
      tick();
      head_is("t2_run", 32'(k));
    end

    // Redirect with full queue {5,6}
    do_reset(1'b1);
    repeat (7) tick();
    head_is("t3_pre", 32'd5);
    if_ready = 1'b0;
    #1;
    tick();
    head_is("t3_full", 32'd5);
    chk("t3_fpc", 32'(fetch_pc), 32'd7);
    chk("t3_fen", 32'(spm_read_enable), 32'd0);
    redirect_enable = 1'b1;
    redirect_pc = 30'h40;
    #1;
    chk("t3_rv",  32'(if_valid), 32'd0);
    chk("t3_ren", 32'(spm_read_enable), 32'd0);
    tick();
    redirect_enable = 1'b0;
    if_ready = 1'b1;
    #1;
    chk("t3_v1",  32'(if_valid), 32'd0);
    chk("t3_en1", 32'(spm_read_enable), 32'd1);
    chk("t3_ad1", 32'(spm_read_address), 32'h40);
    chk("t3_fp1", 32'(fetch_pc), 32'h40);
    tick();
    chk("t3_v2", 32'(if_valid), 32'd0);
    tick();
    head_is("t3_h0", 32'h40);
    tick();
    head_is("t3_h1", 32'h41);

    // Redirect while head valid and if_ready=1, with a word in flight
    redirect_enable = 1'b1;
    redirect_pc = 30'h80;
    #1;
    chk("t4_rv",  32'(if_valid), 32'd0);
    chk("t4_ren", 32'(spm_read_enable), 32'd0);
    tick();
    redirect_enable = 1'b0;
    #1;
    chk("t4_v1",  32'(if_valid), 32'd0);
    chk("t4_fp1", 32'(fetch_pc), 32'h80);
    tick();
    chk("t4_v2", 32'(if_valid), 32'd0);
    tick();
    head_is("t4_h0", 32'h80);
    tick();
    head_is("t4_h1", 32'h81);

    // Back-to-back redirects: last one wins
    redirect_enable = 1'b1;
    redirect_pc = 30'h100;
    #1;
    chk("bb_v0", 32'(if_valid), 32'd0);
    tick();
    redirect_pc = 30'h200;
    #1;
    chk("bb_v1",  32'(if_valid), 32'd0);
    chk("bb_en1", 32'(spm_read_enable), 32'd0);
    chk("bb_fp1", 32'(fetch_pc), 32'h100);
    tick();
    redirect_enable = 1'b0;
    #1;
    chk("bb_fp2", 32'(fetch_pc), 32'h200);
    chk("bb_en2", 32'(spm_read_enable), 32'd1);
    chk("bb_ad2", 32'(spm_read_address), 32'h200);
    tick();
    tick();
    head_is("bb_h0", 32'h200);
    tick();
    head_is("bb_h1", 32'h201);

    // PC wrap-around and SPM address truncation
    redirect_enable = 1'b1;
    redirect_pc = 30'h3FFF_FFFF;
    #1;
    tick();
    redirect_enable = 1'b0;
    #1;
    chk("t5_en", 32'(spm_read_enable), 32'd1);
    chk("t5_ad", 32'(spm_read_address), 32'hFFF);
    tick();
    chk("t5_fpw", 32'(fetch_pc), 32'd0);
    chk("t5_adw", 32'(spm_read_address), 32'd0);
    tick();
    head_is("t5_max", 32'h3FFF_FFFF);
    tick();
    head_is("t5_w0", 32'd0);
    tick();
    head_is("t5_w1", 32'd1);

    // Asynchronous reset mid-stream with a full queue
    if_ready = 1'b0;
    #1;
    tick();
    head_is("t6_full", 32'd1);
    chk("t6_fen", 32'(spm_read_enable), 32'd0);
    reset = 1'b1;
    #1;
    not_valid("t6_rst");
    chk("t6_rpc", 32'(if_pc), 32'd0);
    chk("t6_ren", 32'(spm_read_enable), 32'd0);
    chk("t6_rfp", 32'(fetch_pc), 32'd0);
    tick();
    reset = 1'b0;
    if_ready = 1'b1;
    #1;
    chk("t6_en0", 32'(spm_read_enable), 32'd1);
    chk("t6_ad0", 32'(spm_read_address), 32'd0);
    not_valid("t6_c0");
    tick();
    not_valid("t6_c1");
    tick();
    head_is("t6_h0", 32'd0);
    tick();
    head_is("t6_h1", 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
